// File: rtl/i2c_reg_pkg.sv
// Shared register-map constants for the I2C application register bank.
package i2c_reg_pkg;

    localparam logic [7:0] ADDR_ID          = 8'h00;
    localparam logic [7:0] ADDR_CTRL        = 8'h01;
    localparam logic [7:0] ADDR_IRQ_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_IRQ_MASK    = 8'h03;
    localparam logic [7:0] ADDR_STATUS_LIVE = 8'h04;
    localparam logic [7:0] ADDR_WR_COUNT    = 8'h05;
    localparam logic [7:0] ADDR_ERR         = 8'h06;
    localparam logic [7:0] ADDR_CFG_BASE    = 8'h10;

    localparam int CTRL_CLR_CNT  = 7;
    localparam int CTRL_SOFT_RST = 6;

    localparam logic [7:0] DEVICE_ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Application bus between the I2C peripheral (master) and the register bank (slave).
interface i2c_reg_bank_if;
    logic       wr_rdn;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic [7:0] status;

    modport master (output wr_rdn, addr, wdata, we, input rdata, status);
    modport slave  (input wr_rdn, addr, wdata, we, output rdata, status);
endinterface

// File: rtl/i2c_irq_ctrl.sv
// Event edge detect, sticky W1C flags, mask register and registered interrupt line.
module i2c_irq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] events,
    input  logic [WIDTH-1:0] clr_bits,
    input  logic             flags_clr,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_wdata,
    output logic [WIDTH-1:0] flags,
    output logic [WIDTH-1:0] mask,
    output logic             irq
);

    logic [WIDTH-1:0] events_q;
    logic [WIDTH-1:0] rise;

    assign rise = events & ~events_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events_q <= '0;
            flags    <= '0;
            mask     <= '0;
            irq      <= 1'b0;
        end else begin
            events_q <= events;
            // A new edge in the same cycle as a W1C keeps the flag set.
            if (flags_clr) begin
                flags <= '0;
            end else begin
                flags <= (flags & ~clr_bits) | rise;
            end
            if (mask_we) begin
                mask <= mask_wdata;
            end
            irq <= |(flags & mask);
        end
    end

endmodule

// File: rtl/i2c_reg_bank.sv
// Application register bank behind the I2C peripheral: config, IRQ, status mirror,
// error flag and saturating write counter.
module i2c_reg_bank
    import i2c_reg_pkg::*;
#(
    parameter int         NUM_CFG   = 8,
    parameter logic [7:0] DEVICE_ID = DEVICE_ID_DEFAULT,
    parameter logic [7:0] CFG_RESET = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_reg_bank_if.slave        bus,
    input  logic [7:0]           hw_event_i,
    input  logic [7:0]           status_i,
    output logic [NUM_CFG*8-1:0] cfg_o,
    output logic [7:0]           ctrl_o,
    output logic                 irq_o
);

    logic [7:0] ctrl;
    logic [7:0] wr_count;
    logic       err;
    logic [7:0] cfg [NUM_CFG];
    logic [7:0] status_sync;
    logic [7:0] status_live;
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;
    logic [7:0] irq_flags;
    logic [7:0] irq_mask;

    logic       accept;
    logic       soft_rst;
    logic       cfg_hit;
    logic       legal;
    logic [7:0] cfg_off;
    logic [7:0] irq_clr_bits;

    assign accept   = bus.we & bus.wr_rdn;
    assign soft_rst = ctrl[CTRL_SOFT_RST];
    assign cfg_off  = bus.addr - ADDR_CFG_BASE;
    assign cfg_hit  = (bus.addr >= ADDR_CFG_BASE) && (cfg_off < 8'(NUM_CFG));

    always_comb begin
        legal = cfg_hit ||
                (bus.addr inside {ADDR_CTRL, ADDR_IRQ_STATUS, ADDR_IRQ_MASK, ADDR_ERR});
    end

    assign irq_clr_bits = (accept && bus.addr == ADDR_IRQ_STATUS) ? bus.wdata : 8'h00;

    i2c_irq_ctrl #(.WIDTH(8)) u_irq (
        .clk        (clk),
        .rst_n      (rst_n),
        .events     (hw_event_i),
        .clr_bits   (irq_clr_bits),
        .flags_clr  (soft_rst),
        .mask_we    (accept && bus.addr == ADDR_IRQ_MASK),
        .mask_wdata (bus.wdata),
        .flags      (irq_flags),
        .mask       (irq_mask),
        .irq        (irq_o)
    );

    // CTRL[7:6] are one-shot commands acted on the cycle after they are written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= 8'h00;
        end else if (accept && bus.addr == ADDR_CTRL) begin
            ctrl <= bus.wdata;
        end else begin
            ctrl[CTRL_CLR_CNT]  <= 1'b0;
            ctrl[CTRL_SOFT_RST] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= 8'h00;
        end else if (ctrl[CTRL_CLR_CNT]) begin
            wr_count <= 8'h00;
        end else if (accept && wr_count != 8'hFF) begin
            wr_count <= wr_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (soft_rst) begin
            err <= 1'b0;
        end else if (accept && !legal) begin
            err <= 1'b1;
        end else if (accept && bus.addr == ADDR_ERR && bus.wdata[0]) begin
            err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CFG; i++) cfg[i] <= CFG_RESET;
        end else if (soft_rst) begin
            for (int i = 0; i < NUM_CFG; i++) cfg[i] <= CFG_RESET;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (accept && cfg_hit && cfg_off == 8'(i)) cfg[i] <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_sync <= 8'h00;
            status_live <= 8'h00;
        end else begin
            status_sync <= status_i;
            status_live <= status_sync;
        end
    end

    // Reads must stay side-effect free: the peripheral prefetches addr+1.
    always_comb begin
        rdata_d = 8'h00;
        case (bus.addr)
            ADDR_ID:          rdata_d = DEVICE_ID;
            ADDR_CTRL:        rdata_d = ctrl;
            ADDR_IRQ_STATUS:  rdata_d = irq_flags;
            ADDR_IRQ_MASK:    rdata_d = irq_mask;
            ADDR_STATUS_LIVE: rdata_d = status_live;
            ADDR_WR_COUNT:    rdata_d = wr_count;
            ADDR_ERR:         rdata_d = {7'b0, err};
            default:          rdata_d = 8'h00;
        endcase
        for (int i = 0; i < NUM_CFG; i++) begin
            if (cfg_hit && cfg_off == 8'(i)) rdata_d = cfg[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign cfg_o[8*g +: 8] = cfg[g];
    end

    assign ctrl_o     = ctrl;
    assign bus.rdata  = rdata_q;
    assign bus.status = {irq_o, err, 2'b00, ctrl[3:0]};

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Randomised and directed bench for i2c_reg_bank with a register-map reference model
// and a cycle-tagged scoreboard.
`timescale 1ns/1ps
module tb_i2c_reg_bank;

    localparam int         NUM_CFG = 8;
    localparam logic [7:0] DEV_ID  = 8'hA5;
    localparam logic [7:0] CFG_RST = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] hw_event;
    logic [7:0] status_in;
    logic [NUM_CFG*8-1:0] cfg_o;
    logic [7:0] ctrl_o;
    logic       irq_o;

    i2c_reg_bank_if bus();

    i2c_reg_bank #(.NUM_CFG(NUM_CFG), .DEVICE_ID(DEV_ID), .CFG_RESET(CFG_RST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .hw_event_i (hw_event),
        .status_i   (status_in),
        .cfg_o      (cfg_o),
        .ctrl_o     (ctrl_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  rdata;
        logic [7:0]  status;
        logic [7:0]  ctrl;
        logic        irq;
        logic [63:0] cfg;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: register map contents, commands pending from a CTRL write.
    logic [7:0] m_cfg [NUM_CFG];
    logic [5:0] m_ctrl;
    bit         m_clr_pend, m_srst_pend;
    logic [7:0] m_flags, m_mask, m_count, m_ev_prev, m_sync1, m_sync2, m_rdata;
    bit         m_err, m_irq;
    logic [7:0] hw_cur, st_cur;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(logic [7:0] a);
        int idx;
        idx = int'(a) - 16;
        if (idx >= 0 && idx < NUM_CFG) return m_cfg[idx];
        case (a)
            8'h00:   return DEV_ID;
            8'h01:   return {m_clr_pend, m_srst_pend, m_ctrl};
            8'h02:   return m_flags;
            8'h03:   return m_mask;
            8'h04:   return m_sync2;
            8'h05:   return m_count;
            8'h06:   return {7'd0, m_err};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = CFG_RST;
        m_ctrl = 6'd0; m_clr_pend = 0; m_srst_pend = 0;
        m_flags = 8'h00; m_mask = 8'h00; m_count = 8'h00; m_ev_prev = 8'h00;
        m_sync1 = 8'h00; m_sync2 = 8'h00; m_rdata = 8'h00; m_err = 0; m_irq = 0;
    endtask

    task automatic model_step(bit wr, logic [7:0] a, logic [7:0] d, bit w,
                              logic [7:0] hw, logic [7:0] st);
        logic [7:0] rd, rise, old_flags, old_mask;
        bit acc, is_cfg, legal, old_clr, old_srst;
        int idx;
        rd        = model_read(a);
        acc       = w && wr;
        idx       = int'(a) - 16;
        is_cfg    = acc && idx >= 0 && idx < NUM_CFG;
        legal     = is_cfg || (a inside {8'h01, 8'h02, 8'h03, 8'h06});
        rise      = hw & ~m_ev_prev;
        old_flags = m_flags;
        old_mask  = m_mask;
        old_clr   = m_clr_pend;
        old_srst  = m_srst_pend;

        m_irq = |(old_flags & old_mask);
        if (old_srst) begin
            for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = CFG_RST;
            m_flags = 8'h00;
            m_err   = 0;
        end else begin
            if (acc && a == 8'h02) m_flags = m_flags & ~d;
            m_flags = m_flags | rise;
            if (is_cfg) m_cfg[idx] = d;
            if (acc && a == 8'h06 && d[0]) m_err = 0;
            if (acc && !legal) m_err = 1;
        end
        if (acc && a == 8'h03) m_mask = d;
        m_clr_pend  = acc && a == 8'h01 && d[7];
        m_srst_pend = acc && a == 8'h01 && d[6];
        if (acc && a == 8'h01) m_ctrl = d[5:0];
        if (old_clr) m_count = 8'h00;
        else if (acc && m_count != 8'hFF) m_count = m_count + 8'd1;
        m_ev_prev = hw;
        m_sync2   = m_sync1;
        m_sync1   = st;
        m_rdata   = rd;
    endtask

    function automatic logic [63:0] model_cfg_flat();
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < NUM_CFG; i++) f[8*i +: 8] = m_cfg[i];
        return f;
    endfunction

    // Drive one bus cycle now and queue what the DUT must show after the next edge.
    task automatic step_now(bit wr, logic [7:0] a, logic [7:0] d, bit w);
        exp_t e;
        bus.wr_rdn = wr; bus.addr = a; bus.wdata = d; bus.we = w;
        hw_event = hw_cur; status_in = st_cur;
        model_step(wr, a, d, w, hw_cur, st_cur);
        e.cyc    = cyc_cnt + 1;
        e.rdata  = m_rdata;
        e.status = {m_irq, m_err, 2'b00, m_ctrl[3:0]};
        e.ctrl   = {m_clr_pend, m_srst_pend, m_ctrl};
        e.irq    = m_irq;
        e.cfg    = model_cfg_flat();
        exp_q.push_back(e);
    endtask

    task automatic cyc(bit wr, logic [7:0] a, logic [7:0] d, bit w);
        @(negedge clk);
        step_now(wr, a, d, w);
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        cyc(1'b1, a, d, 1'b1);
    endtask

    task automatic rd(logic [7:0] a);
        cyc(1'b0, a, 8'h00, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rdata",  64'(bus.rdata),  64'h0);
        check("rst_status", 64'(bus.status), 64'h0);
        check("rst_irq",    64'(irq_o),      64'h0);
        check("rst_ctrl",   64'(ctrl_o),     64'h0);
        check("rst_cfg",    64'(cfg_o),      64'({NUM_CFG{CFG_RST}}));
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step_now(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            e = exp_q.pop_front();
            check("sched",  64'(cyc_cnt),    64'(e.cyc));
            check("rdata",  64'(bus.rdata),  64'(e.rdata));
            check("status", 64'(bus.status), 64'(e.status));
            check("ctrl_o", 64'(ctrl_o),     64'(e.ctrl));
            check("irq_o",  64'(irq_o),      64'(e.irq));
            check("cfg_o",  64'(cfg_o),      e.cfg);
        end
    end

    initial begin
        logic [7:0] a, d;
        int sel;
        bus.wr_rdn = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00;
        hw_cur = 8'h00; st_cur = 8'h00; hw_event = 8'h00; status_in = 8'h00;
        model_reset();
        #3 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step_now(1'b0, 8'h00, 8'h00, 1'b0);

        rd(8'h00); rd(8'h10); rd(8'h05); rd(8'h05);

        wr(8'h10, 8'h11); wr(8'h11, 8'h22); wr(8'h12, 8'h33);
        rd(8'h05); rd(8'h06); rd(8'h06);

        wr(8'h00, 8'hFF); wr(8'h7F, 8'h12);
        rd(8'h00); rd(8'h06); rd(8'h05); rd(8'h05);
        wr(8'h06, 8'h01); rd(8'h06); rd(8'h06);

        wr(8'h03, 8'h04);
        hw_cur[2] = 1'b1; rd(8'h02);
        hw_cur[2] = 1'b0; rd(8'h02); rd(8'h02); rd(8'h02);
        hw_cur[2] = 1'b1; wr(8'h02, 8'h04);
        hw_cur[2] = 1'b0; rd(8'h02); rd(8'h02);
        wr(8'h02, 8'h04); rd(8'h02); rd(8'h02); rd(8'h02);

        cyc(1'b0, 8'h11, 8'hFF, 1'b1);
        rd(8'h11); rd(8'h05);
        repeat (300) wr(8'h13, 8'($urandom));
        rd(8'h05); rd(8'h05);
        wr(8'h01, 8'h80); rd(8'h05); rd(8'h01); rd(8'h05);

        wr(8'h10, 8'h5A); wr(8'h01, 8'h41);
        rd(8'h10); rd(8'h02); rd(8'h01); rd(8'h01);

        st_cur = 8'h3C; rd(8'h04); rd(8'h04); rd(8'h04); rd(8'h04);

        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)       a = 8'($urandom_range(0, 6));
            else if (sel < 7)  a = 8'h10 + 8'($urandom_range(0, NUM_CFG));
            else if (sel == 7) a = 8'($urandom);
            else               a = 8'h02;
            d = 8'($urandom);
            if (a == 8'h01 && $urandom_range(0, 3) != 0) d[6] = 1'b0;
            if ($urandom_range(0, 4) == 0) hw_cur = 8'($urandom);
            if ($urandom_range(0, 9) == 0) st_cur = 8'($urandom);
            cyc($urandom_range(0, 4) != 0, a, d, $urandom_range(0, 1) == 1);
        end

        wr(8'h14, 8'hC3); wr(8'h15, 8'h3C);
        mid_reset();
        rd(8'h00); rd(8'h14); rd(8'h05); rd(8'h02); rd(8'h02);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
